bresenham_ctrl: RTL and testbench

- Sequencer for the bresenham_df ray datapath.
- Accepts one laser beam (magnitude, angle, sensor pose) per valid/ready handshake and latches it for the ray's duration.
- Drives x_we/x_source to walk the ray from endpoint back to the sensor cell, issuing one occupancy-map write per cell: occupied at the endpoint, free elsewhere.
- Sits between the scan FIFO and the map RAM write port; addresses come from bresenham_df x_index/y_index.

---
 rtl/bresenham_pkg.sv | 24 ++
 rtl/fixed_pkg.sv | 11 +
 rtl/map_write_hold.sv | 40 ++++
 rtl/bresenham_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bresenham_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/bresenham_pkg.sv
// Shared types and widths for the bresenham ray controller.
package bresenham_pkg;

  localparam int STEP_COUNT_WIDTH    = 16;
  localparam int CELLS_WRITTEN_WIDTH = 16;

  // Ray sequencing states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HIT  = 3'd2,
    STEP = 3'd3,
    FREE = 3'd4,
    DONE = 3'd5
  } ctrl_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CELLS_WRITTEN_WIDTH-1:0] sat_inc(
    input logic [CELLS_WRITTEN_WIDTH-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fixed_pkg.sv
// Fixed-point scalar type shared by the ray datapath and its controller.
// Values are two's complement; grid indices are plain integer counts.
package fixed_pkg;

  localparam int FIXED_WIDTH = 32;

  typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = {1'b0, {(FIXED_WIDTH-1){1'b1}}};

endpackage

// File: rtl/map_write_hold.sv
// Map write port holder: presents a write request to the map RAM and keeps
// map_we/map_occupied stable until map_ready accepts it. write_accepted is a
// one-cycle strobe on the accepting cycle.
// Handshake: a write transfers on every cycle where map_we && map_ready;
// while map_we is high and map_ready low nothing about the write may change.
module map_write_hold (
  input  logic clock,
  input  logic reset_n,
  input  logic req,
  input  logic occupied_in,
  input  logic map_ready,
  output logic map_we,
  output logic map_occupied,
  output logic write_accepted
);

  logic pending_q, pending_d;
  logic occ_q, occ_d;

  // Remember the cell kind of a stalled write so it cannot change while waiting.
  always_comb begin
    map_we         = req;
    map_occupied   = pending_q ? occ_q : occupied_in;
    write_accepted = req && map_ready;
    pending_d      = req && !map_ready;
    occ_d          = map_occupied;
  end

  // Pending flag and captured cell kind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      occ_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      occ_q     <= occ_d;
    end
  end

endmodule

// File: rtl/bresenham_ctrl.sv
// Sequencer for the bresenham_df ray datapath. Latches one beam per
// handshake, loads the endpoint into the datapath x register, writes the
// endpoint occupied and then walks back to the sensor cell writing free cells.
// Optional feature: define BRESENHAM_MAX_RANGE_EN to treat beams with
// magnitude_in >= MAX_RANGE as no-returns (no occupied endpoint write).
// Handshake: a beam transfers on the rising edge where beam_valid && beam_ready;
// beam_ready is high only in IDLE, so the upstream must hold valid while busy.
module bresenham_ctrl
  import fixed_pkg::*;
  import bresenham_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 1023,
  parameter fixed_t      MAX_RANGE = FIXED_MAX
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           beam_valid,
  output logic                           beam_ready,
  input  fixed_t                         magnitude_in,
  input  fixed_t                         angle_in,
  input  fixed_t                         sensor_x_in,
  input  fixed_t                         sensor_y_in,
  output fixed_t                         magnitude,
  output fixed_t                         angle,
  output fixed_t                         sensor_x,
  output fixed_t                         sensor_y,
  output logic                           x_we,
  output logic                           x_source,
  input  fixed_t                         current_x,
  output logic                           map_we,
  output logic                           map_occupied,
  input  logic                           map_ready,
  output logic                           busy,
  output logic                           done,
  output logic [CELLS_WRITTEN_WIDTH-1:0] cells_written
);

  localparam logic [STEP_COUNT_WIDTH-1:0] MAX_STEPS_C = STEP_COUNT_WIDTH'(MAX_STEPS);

  ctrl_state_t                     state_q, state_d;
  fixed_t                          magnitude_q, magnitude_d;
  fixed_t                          angle_q, angle_d;
  fixed_t                          sensor_x_q, sensor_x_d;
  fixed_t                          sensor_y_q, sensor_y_d;
  logic [STEP_COUNT_WIDTH-1:0]     steps_q, steps_d;
  logic [CELLS_WRITTEN_WIDTH-1:0]  cells_q, cells_d;
  logic                            no_return_q, no_return_d;

  logic no_return_in;
  logic at_zero;
  logic write_req;
  logic write_occ;
  logic write_accepted;

`ifdef BRESENHAM_MAX_RANGE_EN
  assign no_return_in = (magnitude_in >= MAX_RANGE);
`else
  logic unused_max_range;
  assign no_return_in     = 1'b0;
  assign unused_max_range = ^MAX_RANGE;
`endif

  // A negative index after loading is handled as the sensor cell.
  assign at_zero = current_x[FIXED_WIDTH-1] || (current_x == '0);

  map_write_hold u_map_write_hold (
    .clock          (clock),
    .reset_n        (reset_n),
    .req            (write_req),
    .occupied_in    (write_occ),
    .map_ready      (map_ready),
    .map_we         (map_we),
    .map_occupied   (map_occupied),
    .write_accepted (write_accepted)
  );

  // Next-state, datapath control and beam latching.
  always_comb begin
    state_d     = state_q;
    magnitude_d = magnitude_q;
    angle_d     = angle_q;
    sensor_x_d  = sensor_x_q;
    sensor_y_d  = sensor_y_q;
    steps_d     = steps_q;
    no_return_d = no_return_q;
    cells_d     = write_accepted ? sat_inc(cells_q) : cells_q;
    beam_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    x_we        = 1'b0;
    x_source    = 1'b0;
    write_req   = 1'b0;
    write_occ   = 1'b0;

    case (state_q)
      IDLE: begin
        beam_ready = 1'b1;
        if (beam_valid) begin
          magnitude_d = magnitude_in;
          angle_d     = angle_in;
          sensor_x_d  = sensor_x_in;
          sensor_y_d  = sensor_y_in;
          no_return_d = no_return_in;
          steps_d     = '0;
          cells_d     = '0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        x_we    = 1'b1;
        state_d = no_return_q ? STEP : HIT;
      end
      HIT: begin
        busy      = 1'b1;
        write_req = 1'b1;
        write_occ = 1'b1;
        if (write_accepted) state_d = at_zero ? DONE : STEP;
      end
      STEP: begin
        busy = 1'b1;
        // Only reachable at the sensor cell straight after a no-return load.
        if (no_return_q && at_zero) begin
          state_d = DONE;
        end else begin
          x_we     = 1'b1;
          x_source = 1'b1;
          steps_d  = steps_q + 1'b1;
          state_d  = FREE;
        end
      end
      FREE: begin
        busy      = 1'b1;
        write_req = 1'b1;
        if (write_accepted) begin
          state_d = (at_zero || steps_q == MAX_STEPS_C) ? DONE : STEP;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched beam registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      magnitude_q <= '0;
      angle_q     <= '0;
      sensor_x_q  <= '0;
      sensor_y_q  <= '0;
      steps_q     <= '0;
      cells_q     <= '0;
      no_return_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      magnitude_q <= magnitude_d;
      angle_q     <= angle_d;
      sensor_x_q  <= sensor_x_d;
      sensor_y_q  <= sensor_y_d;
      steps_q     <= steps_d;
      cells_q     <= cells_d;
      no_return_q <= no_return_d;
    end
  end

  assign magnitude     = magnitude_q;
  assign angle         = angle_q;
  assign sensor_x      = sensor_x_q;
  assign sensor_y      = sensor_y_q;
  assign cells_written = cells_q;

endmodule

// File: tb/tb_bresenham_ctrl.sv
// Bench for bresenham_ctrl: directed beams, a small x-register model standing
// in for the datapath (endpoint = magnitude - angle), and a scoreboard of
// expected map writes and done records checked by a negedge monitor.
module tb_bresenham_ctrl;
  import fixed_pkg::*;

  localparam int     MAX_STEPS_TB = 4;
  localparam fixed_t MAX_RANGE_TB = 32'sd64;

  logic        clock;
  logic        reset_n;
  logic        beam_valid;
  logic        beam_ready;
  fixed_t      magnitude_in, angle_in, sensor_x_in, sensor_y_in;
  fixed_t      magnitude, angle, sensor_x, sensor_y;
  logic        x_we, x_source;
  fixed_t      current_x;
  logic        map_we, map_occupied, map_ready;
  logic        busy, done;
  logic [15:0] cells_written;

  bresenham_ctrl #(.MAX_STEPS(MAX_STEPS_TB), .MAX_RANGE(MAX_RANGE_TB)) dut (
    .clock(clock), .reset_n(reset_n),
    .beam_valid(beam_valid), .beam_ready(beam_ready),
    .magnitude_in(magnitude_in), .angle_in(angle_in),
    .sensor_x_in(sensor_x_in), .sensor_y_in(sensor_y_in),
    .magnitude(magnitude), .angle(angle), .sensor_x(sensor_x), .sensor_y(sensor_y),
    .x_we(x_we), .x_source(x_source), .current_x(current_x),
    .map_we(map_we), .map_occupied(map_occupied), .map_ready(map_ready),
    .busy(busy), .done(done), .cells_written(cells_written)
  );

  // Clock and cycle counter.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Datapath x register model.
  fixed_t x_reg;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  x_reg <= '0;
    else if (x_we) x_reg <= x_source ? x_reg - 1 : magnitude - angle;
  end
  assign current_x = x_reg;

  // Scoreboard.
  logic [32:0] exp_q[$];   // {occupied, x}
  logic [63:0] done_q[$];  // {cells_written, latency, sensor_x}
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_write(input logic occ, input fixed_t x);
    exp_q.push_back({occ, x});
  endtask

  task automatic exp_done(input int cells, input int lat, input fixed_t sx);
    done_q.push_back({16'(cells), 16'(lat), sx});
  endtask

  // Monitor: samples mid-cycle, inputs change only just after rising edges.
  initial begin
    int    accept_cyc;
    logic  prev_we, prev_ready, prev_occ;
    fixed_t prev_x;
    logic [32:0] ew;
    logic [63:0] ed;
    accept_cyc = 0;
    prev_we = 1'b0; prev_ready = 1'b0; prev_occ = 1'b0; prev_x = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_we = 1'b0;
        continue;
      end
      check("we_exclusive", 64'(x_we & map_we), 64'd0);
      check("ready_while_busy", 64'(beam_ready & busy), 64'd0);
      if (prev_we && !prev_ready)
        check("stall_stable", {31'd0, map_we, map_occupied, current_x}, {31'd0, 1'b1, prev_occ, prev_x});
      if (beam_valid && beam_ready) accept_cyc = cyc;
      if (map_we && map_ready) begin
        if (exp_q.size() == 0) check("write_extra", {31'd0, map_occupied, current_x}, 64'hDEAD);
        else begin
          ew = exp_q.pop_front();
          check("map_write", {31'd0, map_occupied, current_x}, {31'd0, ew});
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("done_extra", 64'(cells_written), 64'hDEAD);
        else begin
          ed = done_q.pop_front();
          check("done_record", {cells_written, 16'(cyc - accept_cyc), sensor_x}, ed);
        end
      end
      prev_we = map_we; prev_ready = map_ready; prev_occ = map_occupied; prev_x = current_x;
    end
  end

  // Driver: present a beam and return just after the accepting edge (cycle 1).
  task automatic send_beam(input fixed_t mag, input fixed_t ang, input fixed_t sx, input fixed_t sy);
    bit ok;
    ok = 1'b0;
    @(posedge clock); #1;
    magnitude_in = mag; angle_in = ang; sensor_x_in = sx; sensor_y_in = sy;
    beam_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (beam_ready) begin ok = 1'b1; break; end
    end
    @(posedge clock); #1;
    beam_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      if (!busy && exp_q.size() == 0 && done_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", 64'(exp_q.size() + done_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, {58'd0, beam_ready, busy, done, x_we, map_we, map_occupied}, {58'd0, 6'b100000});
    check({tag, "_cells"}, 64'(cells_written), 64'd0);
    check({tag, "_latched"}, {magnitude, sensor_y}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    reset_n = 1'b0; beam_valid = 1'b0; map_ready = 1'b1;
    magnitude_in = '0; angle_in = '0; sensor_x_in = '0; sensor_y_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // N=3, then N=0, then negative endpoint, back to back.
    exp_write(1'b1, 3); exp_write(1'b0, 2); exp_write(1'b0, 1); exp_write(1'b0, 0);
    exp_done(4, 9, 32'sd11);
    send_beam(32'sd3, 32'sd0, 32'sd11, 32'sd7);
    exp_write(1'b1, 0);
    exp_done(1, 3, 32'sd22);
    send_beam(32'sd0, 32'sd0, 32'sd22, 32'sd1);
    exp_write(1'b1, -3);
    exp_done(1, 3, -32'sd5);
    send_beam(-32'sd3, 32'sd0, -32'sd5, 32'sd2);
    wait_drain();
    repeat (2) @(posedge clock);
    #1 check("cells_hold", 64'(cells_written), 64'd1);

    // N=2 with three stalled cycles on the first free write.
    exp_write(1'b1, 2); exp_write(1'b0, 1); exp_write(1'b0, 0);
    exp_done(3, 10, 32'sd4);
    send_beam(32'sd2, 32'sd0, 32'sd4, 32'sd4);
    repeat (2) @(posedge clock);
    #1 map_ready = 1'b0;
    repeat (4) @(posedge clock);
    #1 map_ready = 1'b1;
    wait_drain();

    // N=10 truncated after MAX_STEPS_TB free cells.
    exp_write(1'b1, 10);
    for (int k = 9; k >= 6; k--) exp_write(1'b0, k);
    exp_done(5, 11, 32'sd9);
    send_beam(32'sd12, 32'sd2, 32'sd9, 32'sd3);
    wait_drain();

    // Reset while the first free write of N=5 is stalled.
    exp_write(1'b1, 5);
    send_beam(32'sd5, 32'sd0, 32'sd8, 32'sd8);
    repeat (2) @(posedge clock);
    #1 map_ready = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1 check_idle_outputs("abort");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1; map_ready = 1'b1;
    check("abort_pending", 64'(exp_q.size() + done_q.size()), 64'd0);

    // Next beam after the abort runs normally.
    exp_write(1'b1, 1); exp_write(1'b0, 0);
    exp_done(2, 5, 32'sd6);
    send_beam(32'sd1, 32'sd0, 32'sd6, 32'sd6);
    wait_drain();

    // Beam at the no-return threshold, endpoint N=2.
`ifdef BRESENHAM_MAX_RANGE_EN
    exp_write(1'b0, 1); exp_write(1'b0, 0);
    exp_done(2, 6, 32'sd3);
`else
    exp_write(1'b1, 2); exp_write(1'b0, 1); exp_write(1'b0, 0);
    exp_done(3, 7, 32'sd3);
`endif
    send_beam(MAX_RANGE_TB, 32'sd62, 32'sd3, 32'sd3);
    wait_drain();

    check("leftover", 64'(exp_q.size() + done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
